// File: rtl/counter_pkg.sv
// Shared widths and record layout for the count snapshot FIFO.
// The record is {wrap, count, even, odd}, MSB first.
package counter_pkg;

  localparam int CNT_W  = 6;
  localparam int EVEN_W = 5;
  localparam int ODD_W  = 4;
  localparam int REC_W  = 16;

  localparam int ODD_LSB  = 0;
  localparam int EVEN_LSB = ODD_LSB + ODD_W;
  localparam int CNT_LSB  = EVEN_LSB + EVEN_W;
  localparam int WRAP_BIT = CNT_LSB + CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic              wrap,
    input logic [CNT_W-1:0]  cnt,
    input logic [EVEN_W-1:0] even,
    input logic [ODD_W-1:0]  odd
  );
    logic [REC_W-1:0] r;
    r = '0;
    r[WRAP_BIT]               = wrap;
    r[CNT_LSB  +: CNT_W]      = cnt;
    r[EVEN_LSB +: EVEN_W]     = even;
    r[ODD_LSB  +: ODD_W]      = odd;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is read straight from storage.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             push_acc;
  logic             pop_acc;

  assign valid    = (cnt != '0);
  assign full     = (cnt == LW'(DEPTH));
  assign pop_acc  = pop && valid;
  assign push_acc = push && (!full || pop_acc);
  assign dout     = mem[rd_ptr];
  assign level    = cnt;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. a full-FIFO push overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      // NOTE: storage is reset (it is tiny) so the head reads 0 after reset
      // instead of X; larger FIFOs would normally leave memory unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_acc) rd_ptr <= ptr_next(rd_ptr);
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Snapshots the upstream counters into a FIFO on request or on count wrap,
// with a sticky overflow flag for pushes dropped while full.
module count_snapshot_fifo
  import counter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AUTO_WRAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             count_in,
  input  logic [4:0]             even_in,
  input  logic [3:0]             odd_in,
  input  logic                   sample_req,
  input  logic                   clr_ovf,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [15:0]            rec_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  logic [CNT_W-1:0] prev_count;
  logic             prev_vld;
  logic             wrap;
  logic             push;
  logic             pop;
  logic             full;
  logic             ovf_set;
  logic [REC_W-1:0] rec;

  // prev_vld masks the reset value of prev_count on the first cycle.
  assign wrap    = prev_vld && (prev_count == CNT_MAX) && (count_in == '0);
  assign push    = sample_req || ((AUTO_WRAP != 0) && wrap);
  assign pop     = rec_valid && rec_ready;
  assign ovf_set = push && full && !pop;
  assign rec     = pack_rec(wrap, count_in, even_in, odd_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_count <= '0;
      prev_vld   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_count <= count_in;
      prev_vld   <= 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rec_ready),
    .din   (rec),
    .valid (rec_valid),
    .dout  (rec_data),
    .level (level),
    .full  (full)
  );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo (DEPTH=4, AUTO_WRAP=1): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_count_snapshot_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  count_in = '0;
  logic [4:0]  even_in = '0;
  logic [3:0]  odd_in = '0;
  logic        sample_req = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [15:0] rec_data;
  logic [2:0]  level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mq[$];
  bit          m_ovf;
  int          m_prev;
  bit          m_pvld;

  count_snapshot_fifo #(.DEPTH(DEPTH), .AUTO_WRAP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .even_in    (even_in),
    .odd_in     (odd_in),
    .sample_req (sample_req),
    .clr_ovf    (clr_ovf),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_data   (rec_data),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic tick();
    bit          wrap, push, pop, set;
    int          size0;
    logic [15:0] r, dummy;
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_prev = 0;
      m_pvld = 0;
    end else begin
      wrap  = m_pvld && (m_prev == 63) && (count_in == 0);
      push  = sample_req || wrap;
      size0 = mq.size();
      pop   = (size0 > 0) && rec_ready;
      r     = {wrap, count_in, even_in, odd_in};
      set   = 0;
      if (pop) dummy = mq.pop_front();
      if (push) begin
        if (size0 < DEPTH || pop) mq.push_back(r);
        else set = 1;
      end
      m_ovf  = set || (m_ovf && !clr_ovf);
      m_prev = int'(count_in);
      m_pvld = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; sample_req = 0; clr_ovf = 0; rec_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push_one(input logic [5:0] c, input logic [4:0] e, input logic [3:0] o);
    count_in = c; even_in = e; odd_in = o; sample_req = 1;
    tick();
    sample_req = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_checks += 4;
    if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", rec_valid); end
    if (level !== 3'd0)     begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    if (rec_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", rec_data); end
  endtask

  task automatic test_sample();
    do_reset();
    push_one(6'd5, 5'd3, 4'd2);
    n_checks += 3;
    if (rec_valid !== 1'b1)    begin n_fail++; $display("FAIL sample_valid got %0b want 1", rec_valid); end
    if (rec_data !== 16'h0A32) begin n_fail++; $display("FAIL sample_data got %h want 0a32", rec_data); end
    if (level !== 3'd1)        begin n_fail++; $display("FAIL sample_level got %0d want 1", level); end
    // Held head must stay stable while not accepted.
    count_in = 6'd20; even_in = 5'd9; odd_in = 4'd7;
    tick();
    n_checks += 2;
    if (rec_data !== 16'h0A32 || rec_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_stable got %h/%0b want 0a32/1", rec_data, rec_valid);
    end
    if (level !== 3'd1) begin n_fail++; $display("FAIL hold_level got %0d want 1", level); end
    rec_ready = 1;
    tick();
    n_checks += 2;
    if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid got %0b want 0", rec_valid); end
    if (level !== 3'd0)     begin n_fail++; $display("FAIL pop_level got %0d want 0", level); end
    tick();
    n_checks++;
    if (level !== 3'd0 || rec_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_ready got level %0d valid %0b want 0/0", level, rec_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rec_ready = 1; even_in = 5'd17; odd_in = 4'd9;
    count_in = 6'd0;
    tick();
    n_checks++;
    if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first_cycle got %0b want 0", rec_valid); end
    count_in = 6'd62; tick();
    count_in = 6'd63; tick();
    n_checks++;
    if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early got %0b want 0", rec_valid); end
    count_in = 6'd0; tick();
    n_checks += 2;
    if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %0b want 1", rec_valid); end
    if (rec_data !== {1'b1, 6'd0, 5'd17, 4'd9}) begin
      n_fail++; $display("FAIL wrap_data got %h want %h", rec_data, {1'b1, 6'd0, 5'd17, 4'd9});
    end
    count_in = 6'd1; tick();
    n_checks++;
    if (rec_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL wrap_single got valid %0b level %0d want 0/0", rec_valid, level);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp[i] = {1'b0, 6'(10 + i), 5'(i + 1), 4'(i + 3)};
      push_one(6'(10 + i), 5'(i + 1), 4'(i + 3));
    end
    n_checks += 2;
    if (level !== 3'd4)    begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rec_valid !== 1'b1 || rec_data !== exp[i]) begin
        n_fail++; $display("FAIL ovf_order[%0d] got %h/%0b want %h/1", i, rec_data, rec_valid, exp[i]);
      end
      tick();
    end
    n_checks++;
    if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth_lost got valid %0b want 0", rec_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp [5];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp[i] = {1'b0, 6'(30 + i), 5'(2 * i), 4'(15 - i)};
      push_one(6'(30 + i), 5'(2 * i), 4'(15 - i));
    end
    exp[4] = {1'b0, 6'd40, 5'd21, 4'd6};
    rec_ready = 1;
    push_one(6'd40, 5'd21, 4'd6);
    n_checks += 3;
    if (level !== 3'd4)      begin n_fail++; $display("FAIL fpp_level got %0d want 4", level); end
    if (overflow !== 1'b0)   begin n_fail++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
    if (rec_data !== exp[1]) begin n_fail++; $display("FAIL fpp_head got %h want %h", rec_data, exp[1]); end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (rec_data !== exp[i]) begin n_fail++; $display("FAIL fpp_order[%0d] got %h want %h", i, rec_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_clr_ovf();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(6'(i + 1), 5'd1, 4'd1);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre got %0b want 1", overflow); end
    clr_ovf = 1; tick(); clr_ovf = 0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %0b want 0", overflow); end
    push_one(6'd7, 5'd2, 4'd2);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_reset got %0b want 1", overflow); end
    clr_ovf = 1;
    push_one(6'd8, 5'd2, 4'd2);
    clr_ovf = 0;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got %0b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(6'(50 + i), 5'd4, 4'd4);
    n_checks++;
    if (level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", level); end
    rst = 1; sample_req = 1; count_in = 6'd12;
    tick();
    rst = 0; sample_req = 0;
    n_checks++;
    if (rec_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset got valid %0b level %0d want 0/0", rec_valid, level);
    end
    tick();
    n_checks++;
    if (rec_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL mid_no_record got valid %0b level %0d want 0/0", rec_valid, level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      sample_req = ($urandom_range(0, 2) == 0);
      clr_ovf    = ($urandom_range(0, 7) == 0);
      rec_ready  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) count_in = 6'($urandom);
      else                           count_in = count_in + 6'd1;
      even_in = 5'($urandom);
      odd_in  = 4'($urandom);
      tick();
      n_checks += 3;
      if (rec_valid !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL rand_valid[%0d] got %0b want %0b", n, rec_valid, mq.size() > 0);
      end
      if (level !== 3'(mq.size())) begin
        n_fail++; $display("FAIL rand_level[%0d] got %0d want %0d", n, level, mq.size());
      end
      if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_ovf[%0d] got %0b want %0b", n, overflow, m_ovf);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (rec_data !== mq[0]) begin
          n_fail++; $display("FAIL rand_data[%0d] got %h want %h", n, rec_data, mq[0]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sample();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_clr_ovf();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 Parameter DEPTH, default 4; number of record slots; power of two, 2..16.
REQ-002 Parameter AUTO_WRAP, default 1; 1 = push a record automatically on each count wrap, 0 = push on sample_req only.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 count_in  input  6  upstream free-running count.
REQ-006 even_in  input  5  upstream even-cycle count.
REQ-007 odd_in  input  4  upstream odd-cycle count.
REQ-008 sample_req  input  1  request to snapshot the current inputs; single-cycle pulse or level.
REQ-009 clr_ovf  input  1  clears the overflow flag.
REQ-010 rec_valid  output  1  the head record is available.
REQ-011 rec_ready  input  1  consumer accepts the head record.
REQ-012 rec_data  output  16  head record, packed as {wrap, count[5:0], even[4:0], odd[3:0]}.
REQ-013 level  output  $clog2(DEPTH)+1  number of stored records.
REQ-014 overflow  output  1  sticky flag; a push was dropped.

Function
REQ-015 Wrap event: prev_count==63, count_in==0 and prev_vld==1.
  - prev_count is count_in registered every cycle.
  - prev_vld is 0 after reset and becomes 1 after the first post-reset cycle.
REQ-016 Push condition: sample_req==1, or (AUTO_WRAP==1 and wrap event).
  - Exactly one record is pushed per cycle, even if both causes are true.
REQ-017 Pushed record: wrap bit = wrap event in that cycle; remaining fields = count_in, even_in and odd_in of that same cycle.
REQ-018 Pop occurs when rec_valid and rec_ready are both 1 in a cycle.
REQ-019 A record pushed in cycle N appears on rec_data with rec_valid=1 in cycle N+1 if the FIFO was empty.
  - Output is first-word-fall-through.
  - Output is driven from registers only.
REQ-020 rec_data and rec_valid shall stay stable while rec_valid=1 and rec_ready=0.
REQ-021 Records are popped in push order.
REQ-022 level is updated in the cycle after a push or pop: +1 for push only, -1 for pop only, unchanged for simultaneous push and pop.
REQ-023 Full (level==DEPTH), push and pop together: both are accepted; level stays DEPTH; overflow is not set.
REQ-024 Full, push and no pop: the push is dropped; stored contents are unchanged; overflow is set to 1 next cycle.
REQ-025 Empty, with rec_ready=1: nothing happens; level stays 0.
REQ-026 Empty and push in the same cycle: no same-cycle bypass; the record becomes visible the next cycle.
REQ-027 overflow stays 1 until clr_ovf=1.
  - If clr_ovf and a new overflow occur in the same cycle, overflow stays 1 (set wins).
REQ-028 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.

Reset
REQ-029 rst=1 at a clock edge sets: rec_valid=0, level=0, overflow=0, pointers=0, prev_count=0, prev_vld=0.
REQ-030 Reset mid-operation discards all stored records.
  - No push or pop is accepted in a cycle where rst=1.
REQ-031 rec_data contents after reset are don't-care while rec_valid=0; the implementation shall still drive it to 0.

Structure
REQ-032 Shared package counter_pkg holds:
  - widths CNT_W=6, EVEN_W=5, ODD_W=4, REC_W=16;
  - field offsets for the record fields.
REQ-033 Storage and pointer logic live in one sub-module, sync_fifo (parameters WIDTH and DEPTH, same reset scheme).
  - Wrap detection, push arbitration and overflow logic live in count_snapshot_fifo.

Verification
REQ-034 Reset, then sample_req pulse with count_in=5, even_in=3, odd_in=2 -> next cycle rec_valid=1, rec_data=0x0A32, level=1.
REQ-035 AUTO_WRAP=1, count_in stepping 62, 63, 0 with rec_ready=1 -> one record with wrap=1 and count=0; no wrap record in the first cycle after reset.
REQ-036 DEPTH=4, five pushes with rec_ready=0 -> level=4, overflow=1; first four records retained in order; fifth record lost.
REQ-037 Full FIFO, push and pop in the same cycle -> level stays 4, overflow stays 0, head advances by one record.
REQ-038 overflow=1, clr_ovf pulse with no push -> overflow=0 next cycle; clr_ovf together with a dropped push -> overflow stays 1.
REQ-039 level=3, assert rst for one cycle -> next cycle rec_valid=0 and level=0; a sample_req in the reset cycle produces no record.
